// File: rtl/shift_rs_pkg.sv
// Shared types for the shift reservation station: tags, shift ops, CDB terms,
// operand slots and the station FSM encoding.
package shift_rs_pkg;

    typedef logic [31:0] word32_t;

    // Producer tags; NO_VAL marks an operand whose value is already present.
    typedef enum logic [2:0] {
        NO_VAL  = 3'd0,
        ALU_1   = 3'd1,
        ALU_2   = 3'd2,
        MUL_1   = 3'd3,
        LSU_1   = 3'd4,
        SHIFT_1 = 3'd5,
        BR_1    = 3'd6
    } rs_tag_t;

    // Shift operations; SLLR is the reset/default encoding.
    typedef enum logic [2:0] {
        SLLR = 3'd0,
        SRLR = 3'd1,
        SRAR = 3'd2,
        SLLI = 3'd3,
        SRLI = 3'd4,
        SRAI = 3'd5
    } shift_op_t;

    // One common-data-bus broadcast term.
    typedef struct packed {
        rs_tag_t tag;
        word32_t val;
    } cdb_t;

    // One source operand held by the station.
    typedef struct packed {
        rs_tag_t tag;
        word32_t val;
    } rs_operand_t;

    // Station FSM encoding, kept as plain constants for legacy tooling.
    typedef logic [1:0] rs_state_t;
    localparam rs_state_t EMPTY = 2'd0;
    localparam rs_state_t WAIT  = 2'd1;
    localparam rs_state_t BCAST = 2'd2;

    // Upper bound on the number of CDB terms a station may snoop.
    localparam int MAX_CDB = 4;

    // A CDB term satisfies a waiting operand when it carries that producer's tag.
    // A NO_VAL term is an idle bus and never matches.
    function automatic logic cdb_match(cdb_t term, rs_tag_t tag);
        return (term.tag != NO_VAL) && (term.tag == tag);
    endfunction

endpackage

// File: rtl/shift_rs_if.sv
// Dispatch-to-station issue handshake.
// Handshake: the dispatcher holds issue_valid_i and the payload steady; a uop
// transfers on a rising clk_i edge where issue_valid_i && issue_ready_o.
// issue_ready_o does not depend on issue_valid_i.
interface shift_rs_if;
    import shift_rs_pkg::*;

    logic      issue_valid_i;
    logic      issue_ready_o;
    shift_op_t issue_op_i;
    rs_tag_t   issue_rs1_tag_i;
    rs_tag_t   issue_rs2_tag_i;
    word32_t   issue_rs1_val_i;
    word32_t   issue_rs2_val_i;

    // Dispatch side.
    modport master (
        output issue_valid_i,
        output issue_op_i,
        output issue_rs1_tag_i,
        output issue_rs2_tag_i,
        output issue_rs1_val_i,
        output issue_rs2_val_i,
        input  issue_ready_o
    );

    // Reservation station side.
    modport slave (
        input  issue_valid_i,
        input  issue_op_i,
        input  issue_rs1_tag_i,
        input  issue_rs2_tag_i,
        input  issue_rs1_val_i,
        input  issue_rs2_val_i,
        output issue_ready_o
    );

endinterface

// File: rtl/shift_rs_operand_slot.sv
// One source-operand slot: loads at dispatch (taking a same-cycle CDB value
// when the producer is broadcasting right now), then snoops the CDB until its
// value arrives. Lower CDB indices win when several terms match.
module rs_operand_slot
    import shift_rs_pkg::*;
#(
    parameter int NUM_CDB = 1
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    flush_i,
    input  logic    load_i,
    input  rs_tag_t load_tag_i,
    input  word32_t load_val_i,
    input  cdb_t    cdb_i [NUM_CDB],
    output word32_t val_o,
    output logic    ready_o
);

    rs_operand_t entry_q;
    logic        load_hit;
    word32_t     load_hit_val;
    logic        snoop_hit;
    word32_t     snoop_val;

    // Priority search over the CDB for the dispatch tag and the held tag; the
    // descending walk lets the lowest matching index overwrite last.
    always_comb begin
        load_hit     = 1'b0;
        load_hit_val = '0;
        snoop_hit    = 1'b0;
        snoop_val    = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_match(cdb_i[k], load_tag_i)) begin
                load_hit     = 1'b1;
                load_hit_val = cdb_i[k].val;
            end
            if (cdb_match(cdb_i[k], entry_q.tag)) begin
                snoop_hit = 1'b1;
                snoop_val = cdb_i[k].val;
            end
        end
    end

    // Slot register: clear on reset/flush, load on accept, else capture a match.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            entry_q <= '{tag: NO_VAL, val: '0};
        end else if (load_i) begin
            if (load_hit) begin
                entry_q <= '{tag: NO_VAL, val: load_hit_val};
            end else begin
                entry_q <= '{tag: load_tag_i, val: load_val_i};
            end
        end else if (snoop_hit) begin
            entry_q <= '{tag: NO_VAL, val: snoop_val};
        end
    end

    assign val_o   = entry_q.val;
    assign ready_o = (entry_q.tag == NO_VAL);

endmodule

// File: rtl/shift_rs.sv
// Single-entry reservation station in front of one shifter. Holds a uop until
// both operands are present, fires the shifter for one cycle, then keeps the
// tag reserved through the shifter's broadcast cycle.
module shift_rs
    import shift_rs_pkg::*;
#(
    parameter rs_tag_t TAG     = SHIFT_1,
    parameter int      NUM_CDB = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    shift_rs_if.slave        issue,
    input  cdb_t             cdb_i [NUM_CDB],
    output shift_op_t        oper_o,
    output word32_t          rs1_val_o,
    output word32_t          rs2_val_o,
    output logic             fire_o,
    output logic             busy_o,
    output rs_state_t        state_o
);

    // The station broadcasts under TAG, so it cannot be the "value present" tag.
    if (NUM_CDB < 1 || NUM_CDB > MAX_CDB || TAG == NO_VAL) begin : g_param_check
        $error("shift_rs: bad parameters (NUM_CDB out of range or TAG is NO_VAL)");
    end

    rs_state_t state_q;
    rs_state_t state_d;
    shift_op_t op_q;
    logic      accept;
    logic      fire;
    logic      rs1_ready;
    logic      rs2_ready;

    // Flush squashes any same-cycle dispatch.
    assign issue.issue_ready_o = (state_q == EMPTY) || (state_q == BCAST);
    assign accept = issue.issue_valid_i && issue.issue_ready_o && !flush_i;

    // Operands captured at an edge are visible here only from the next cycle,
    // so there is no CDB-to-fire combinational path.
    assign fire = (state_q == WAIT) && rs1_ready && rs2_ready && !flush_i && !rst_i;

    rs_operand_slot #(.NUM_CDB(NUM_CDB)) u_rs1 (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .load_i     (accept),
        .load_tag_i (issue.issue_rs1_tag_i),
        .load_val_i (issue.issue_rs1_val_i),
        .cdb_i      (cdb_i),
        .val_o      (rs1_val_o),
        .ready_o    (rs1_ready)
    );

    rs_operand_slot #(.NUM_CDB(NUM_CDB)) u_rs2 (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .load_i     (accept),
        .load_tag_i (issue.issue_rs2_tag_i),
        .load_val_i (issue.issue_rs2_val_i),
        .cdb_i      (cdb_i),
        .val_o      (rs2_val_o),
        .ready_o    (rs2_ready)
    );

    // Next state: flush empties the station; BCAST can take a new uop directly.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_d = WAIT;
                WAIT:    if (fire)   state_d = BCAST;
                BCAST:   state_d = accept ? WAIT : EMPTY;
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and op registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            op_q    <= SLLR;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= issue.issue_op_i;
            end
        end
    end

    assign oper_o  = op_q;
    assign fire_o  = fire;
    assign busy_o  = (state_q != EMPTY);
    assign state_o = state_q;

endmodule

// File: tb/tb_shift_rs.sv
// Directed and randomized bench for shift_rs. The bench plays the paired
// shifter: a cycle after fire_o it drives cdb_i[0] with TAG and the shifted
// result. cdb_i[1] stands in for the other producers in the core.
module tb_shift_rs;
    import shift_rs_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic      clk_i = 1'b0;
    logic      rst_i;
    logic      flush_i;
    cdb_t      cdb [2];
    shift_op_t oper_o;
    word32_t   rs1_val_o;
    word32_t   rs2_val_o;
    logic      fire_o;
    logic      busy_o;
    rs_state_t state_o;

    shift_rs_if bus ();

    shift_rs #(.TAG(SHIFT_1), .NUM_CDB(2)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .issue     (bus),
        .cdb_i     (cdb),
        .oper_o    (oper_o),
        .rs1_val_o (rs1_val_o),
        .rs2_val_o (rs2_val_o),
        .fire_o    (fire_o),
        .busy_o    (busy_o),
        .state_o   (state_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard ----------------
    int            n_assert = 0;
    int            n_fail   = 0;
    logic [31:0]   exp_q[$];
    logic          last_fire;
    word32_t       last_res;

    // Behavioural shifter: amount is the low five bits of the second operand.
    function automatic word32_t shift_ref(shift_op_t op, word32_t a, word32_t b);
        int unsigned amt;
        amt = int'(b[4:0]);
        case (op)
            SLLR, SLLI: return a << amt;
            SRLR, SRLI: return a >> amt;
            SRAR, SRAI: return word32_t'($signed(a) >>> amt);
            default:    return '0;
        endcase
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one cycle; inputs return to idle, and the shifter model
    // broadcasts if the station fired in the cycle just ended.
    task automatic tick();
        last_fire = fire_o;
        last_res  = shift_ref(oper_o, rs1_val_o, rs2_val_o);
        @(posedge clk_i);
        #1;
        rst_i             = 1'b0;
        flush_i           = 1'b0;
        bus.issue_valid_i = 1'b0;
        cdb[0] = last_fire ? '{tag: SHIFT_1, val: last_res} : '{tag: NO_VAL, val: $urandom()};
        cdb[1] = '{tag: NO_VAL, val: $urandom()};
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_issue(input shift_op_t op, input rs_tag_t t1, input word32_t v1,
                            input rs_tag_t t2, input word32_t v2);
        bus.issue_valid_i   = 1'b1;
        bus.issue_op_i      = op;
        bus.issue_rs1_tag_i = t1;
        bus.issue_rs1_val_i = v1;
        bus.issue_rs2_tag_i = t2;
        bus.issue_rs2_val_i = v2;
    endtask

    // ---------------- stimulus ----------------
    shift_op_t r_op;
    word32_t   r_a, r_b;
    rs_tag_t   r_t1, r_t2;
    int        r_d1, r_d2, r_fire_off;

    initial begin
        rst_i   = 1'b1;
        flush_i = 1'b0;
        do_issue(SLLR, NO_VAL, '0, NO_VAL, '0);
        bus.issue_valid_i = 1'b0;
        cdb[0] = '{tag: NO_VAL, val: '0};
        cdb[1] = '{tag: NO_VAL, val: '0};
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        settle();

        // Reset values
        chk1("rst_ready", bus.issue_ready_o, 1'b1);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_fire", fire_o, 1'b0);
        chk32("rst_oper", 32'(oper_o), 32'(SLLR));
        chk32("rst_rs1", rs1_val_o, 32'h0);
        chk32("rst_rs2", rs2_val_o, 32'h0);

        // Ready dispatch: SLLI 1 by 4
        tick(); do_issue(SLLI, NO_VAL, 32'h1, NO_VAL, 32'd4); settle();
        chk1("rd_ready", bus.issue_ready_o, 1'b1);
        chk1("rd_fire_accept_cycle", fire_o, 1'b0);
        tick(); settle();
        chk1("rd_fire", fire_o, 1'b1);
        chk32("rd_oper", 32'(oper_o), 32'(SLLI));
        chk32("rd_res", shift_ref(oper_o, rs1_val_o, rs2_val_o), 32'h0000_0010);
        tick(); settle();
        chk1("rd_bcast_fire", fire_o, 1'b0);
        chk1("rd_bcast_busy", busy_o, 1'b1);
        chk1("rd_bcast_ready", bus.issue_ready_o, 1'b1);
        tick(); settle();
        chk1("rd_empty_busy", busy_o, 1'b0);

        // Wait on producer: SRAR with rs1 from ALU_1, rs2 = 8
        tick(); do_issue(SRAR, ALU_1, 32'h1234_5678, NO_VAL, 32'd8); settle();
        for (int i = 0; i < 5; i++) begin
            tick(); settle();
            chk1("wt_hold_fire", fire_o, 1'b0);
            chk1("wt_hold_ready", bus.issue_ready_o, 1'b0);
        end
        tick(); cdb[1] = '{tag: ALU_1, val: 32'h8000_0000}; settle();
        chk1("wt_cdb_cycle_fire", fire_o, 1'b0);
        tick(); settle();
        chk1("wt_fire", fire_o, 1'b1);
        chk32("wt_rs1", rs1_val_o, 32'h8000_0000);
        chk32("wt_res", shift_ref(oper_o, rs1_val_o, rs2_val_o), 32'hFF80_0000);
        tick(); settle();
        chk1("wt_single_fire", fire_o, 1'b0);
        tick(); settle();

        // Dispatch bypass: producer broadcasts in the accept cycle
        tick(); do_issue(SRLR, ALU_1, 32'h0, NO_VAL, 32'd4);
        cdb[1] = '{tag: ALU_1, val: 32'hF000_0000}; settle();
        tick(); settle();
        chk1("bp_fire", fire_o, 1'b1);
        chk32("bp_res", shift_ref(oper_o, rs1_val_o, rs2_val_o), 32'h0F00_0000);
        tick(); settle();
        tick(); settle();

        // CDB priority: two terms carry the same tag, index 0 wins
        tick(); do_issue(SRLI, LSU_1, 32'h0, NO_VAL, 32'd4); settle();
        tick(); cdb[0] = '{tag: LSU_1, val: 32'h100}; cdb[1] = '{tag: LSU_1, val: 32'h200}; settle();
        chk1("pr_cdb_cycle_fire", fire_o, 1'b0);
        tick(); settle();
        chk1("pr_fire", fire_o, 1'b1);
        chk32("pr_rs1", rs1_val_o, 32'h100);
        tick(); settle();
        tick(); settle();

        // Back-to-back: second uop takes the first result through bypass
        tick(); do_issue(SLLR, NO_VAL, 32'h1, NO_VAL, 32'h1); settle();
        tick(); settle();
        chk1("bb1_fire", fire_o, 1'b1);
        chk32("bb1_res", shift_ref(oper_o, rs1_val_o, rs2_val_o), 32'h2);
        tick(); do_issue(SLLI, SHIFT_1, 32'h0, NO_VAL, 32'd2); settle();
        chk1("bb_bcast_ready", bus.issue_ready_o, 1'b1);
        chk1("bb_bcast_fire", fire_o, 1'b0);
        tick(); settle();
        chk1("bb2_fire", fire_o, 1'b1);
        chk32("bb2_rs1", rs1_val_o, 32'h2);
        chk32("bb2_res", shift_ref(oper_o, rs1_val_o, rs2_val_o), 32'h8);
        tick(); settle();
        chk1("bb2_bcast_busy", busy_o, 1'b1);
        tick(); settle();
        chk1("bb_empty_busy", busy_o, 1'b0);

        // Flush in the cycle fire would rise
        tick(); do_issue(SRLR, ALU_2, 32'h0, NO_VAL, 32'd3); settle();
        tick(); cdb[1] = '{tag: ALU_2, val: 32'hF0}; settle();
        tick(); flush_i = 1'b1; settle();
        chk1("fl_fire_masked", fire_o, 1'b0);
        tick(); settle();
        chk1("fl_busy", busy_o, 1'b0);
        chk1("fl_ready", bus.issue_ready_o, 1'b1);
        chk1("fl_fire_after", fire_o, 1'b0);
        tick(); settle();
        chk1("fl_no_late_fire", fire_o, 1'b0);

        // Flush overrides a same-cycle accept
        tick(); do_issue(SLLR, NO_VAL, 32'h3, NO_VAL, 32'h1); flush_i = 1'b1; settle();
        tick(); settle();
        chk1("fla_busy", busy_o, 1'b0);
        chk1("fla_fire", fire_o, 1'b0);

        // Reset mid-operation
        tick(); do_issue(SRAI, MUL_1, 32'h0, NO_VAL, 32'd1); settle();
        tick(); rst_i = 1'b1; settle();
        chk1("rm_fire_in_reset", fire_o, 1'b0);
        tick(); cdb[1] = '{tag: MUL_1, val: 32'h4444_0000}; settle();
        chk1("rm_ready", bus.issue_ready_o, 1'b1);
        chk1("rm_busy", busy_o, 1'b0);
        chk32("rm_oper", 32'(oper_o), 32'(SLLR));
        tick(); settle();
        chk1("rm_no_fire", fire_o, 1'b0);
        chk32("rm_rs1", rs1_val_o, 32'h0);

        // Randomized uops against the timing/result model
        for (int n = 0; n < 40; n++) begin
            r_op = shift_op_t'($urandom_range(0, 5));
            r_a  = $urandom();
            r_b  = $urandom();
            r_t1 = ($urandom_range(0, 1) == 1) ? ALU_1 : NO_VAL;
            r_t2 = ($urandom_range(0, 1) == 1) ? MUL_1 : NO_VAL;
            r_d1 = (r_t1 == NO_VAL) ? 0 : $urandom_range(0, 4);
            r_d2 = (r_t2 == NO_VAL) ? 0 : $urandom_range(0, 4);
            if (r_t1 != NO_VAL && r_t2 != NO_VAL && r_d1 == r_d2) r_d2++;
            r_fire_off = ((r_d1 > r_d2) ? r_d1 : r_d2) + 1;

            tick();
            if ($urandom_range(0, 1) == 1) begin
                settle();
                tick();
            end
            do_issue(r_op, r_t1, (r_t1 == NO_VAL) ? r_a : ~r_a, r_t2, (r_t2 == NO_VAL) ? r_b : ~r_b);
            if (r_t1 != NO_VAL && r_d1 == 0) cdb[1] = '{tag: ALU_1, val: r_a};
            if (r_t2 != NO_VAL && r_d2 == 0) cdb[1] = '{tag: MUL_1, val: r_b};
            settle();
            chk1("rnd_ready", bus.issue_ready_o, 1'b1);
            exp_q.push_back(shift_ref(r_op, r_a, r_b));

            for (int c = 1; c <= r_fire_off; c++) begin
                tick();
                if (r_t1 != NO_VAL && r_d1 == c) cdb[1] = '{tag: ALU_1, val: r_a};
                if (r_t2 != NO_VAL && r_d2 == c) cdb[1] = '{tag: MUL_1, val: r_b};
                settle();
                chk1("rnd_fire", fire_o, (c == r_fire_off));
            end
            chk32("rnd_oper", 32'(oper_o), 32'(r_op));
            chk32("rnd_rs1", rs1_val_o, r_a);
            chk32("rnd_rs2", rs2_val_o, r_b);
            chk32("rnd_res", shift_ref(oper_o, rs1_val_o, rs2_val_o), exp_q.pop_front());
        end
        tick(); settle();
        chk1("rnd_bcast_fire", fire_o, 1'b0);
        tick(); settle();
        chk1("end_busy", busy_o, 1'b0);
        chk32("end_queue_empty", 32'(exp_q.size()), 32'd0);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
